rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Sequences all write traffic into the per-thread register file bank, which has a single shared write bus (wr_en/wr_trd/reg_wr/wr_data) and a single init bus (init/init_trd/init_data).
- Arbitrates NUM_SRC writeback sources (ALU, load return, misc) round-robin, with a small FIFO per source.
- Gives thread-init requests absolute priority.
- Sits between the execute/memory stages and the regfile instances.

Parameters:
- NUM_SRC, 3, number of writeback sources.
- FIFO_DEPTH, 2, entries per source FIFO (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- src_valid  in  NUM_SRC  per-source write request
- src_ready  out  NUM_SRC  per-source FIFO not full
- src_trd  in  NUM_SRC*3  target thread per source
- src_reg  in  NUM_SRC*5  target register per source
- src_data  in  NUM_SRC*32  write data per source
- init_req  in  1  thread-init request (level, held until ack)
- init_req_trd  in  3  thread to init
- init_req_data  in  32  init value for r4
- init_ack  out  1  one-cycle pulse, init request accepted
- wr_en  out  1  regfile write enable
- wr_trd  out  3  regfile write thread
- reg_wr  out  5  regfile write register
- wr_data  out  32  regfile write data
- init  out  1  regfile init strobe
- init_trd  out  3  regfile init thread
- init_data  out  32  regfile init data

Behaviour:
- Reset (async, rst=1):
  - FIFOs flushed; RR pointer = 0.
  - All outputs 0, except src_ready = all 1s once rst deasserts.
  - Reset asserted mid-operation discards all queued writes and any pending init.
- Push:
  - src_valid[i] & src_ready[i] writes {trd, reg, data} into FIFO i.
  - src_ready[i] = !full[i]; it depends only on FIFO state.
  - No pass-through: a push into a full FIFO is impossible. Push and pop in the same cycle on a non-full FIFO are both honoured.
- Arbitration runs every cycle and makes exactly one decision:
  1. If init_req = 1: init_ack = 1 this cycle. Next cycle, init = 1, init_trd = init_req_trd, init_data = init_req_data, wr_en = 0. No FIFO is popped.
  2. Otherwise, if any FIFO is non-empty: grant the first non-empty FIFO at or after the RR pointer (wrapping NUM_SRC-1 -> 0), and pop its head.
     - If head reg >= 2: next cycle wr_en = 1 with the head fields.
     - If head reg is 0 or 1: the entry is dropped (popped, wr_en stays 0).
     - Either way, RR pointer = grant+1 mod NUM_SRC.
  3. Otherwise: wr_en = 0, init = 0.
- All write/init outputs are registered; each is high for exactly one cycle per issued operation.
- Latency:
  - src push -> wr_en is 2 cycles minimum (push cycle, arbitration cycle, then output).
  - init_req -> init is 1 cycle after init_ack.
- Ordering:
  - FIFO order is preserved within a source.
  - There is no ordering guarantee across sources. Producers must not issue same-thread/same-register writes from two sources in flight.
- init and wr_en are never high in the same cycle.
- A continuously held init_req starves all sources; the caller deasserts it after init_ack.

Optional Feature:
- Macro: TK_WB_CONFLICT_CNT_EN
- When defined:
  - Output conflict_cnt (16 bits), reset to 0.
  - Increments each cycle in which the arbitration decision leaves at least one non-empty FIFO unserviced, including init-priority cycles with any FIFO non-empty.
  - Saturates at 16'hFFFF.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package tk_pkg holds:
  - constants NUM_TRD = 8, TRD_W = 3, REG_W = 5, DATA_W = 32
  - typedef wb_req_t {trd, reg, data}
- One sub-module, rf_wb_fifo: synchronous FIFO of wb_req_t, parameter DEPTH, with push, pop, full, empty and head ports.
- RR arbiter and output registers stay in the top module.

Test Plan:
- Single source: src0 pushes {trd=2, reg=5, data=32'hDEAD_BEEF} -> 2 cycles later, one-cycle wr_en=1, wr_trd=2, reg_wr=5, wr_data=32'hDEAD_BEEF.
- RR fairness: all 3 sources hold 2 entries each, no init -> grants come out 0,1,2,0,1,2 on consecutive cycles, six wr_en pulses.
- Init priority: init_req=1 (trd=3, data=32'h10) while src1 is non-empty -> init_ack that cycle, init=1/init_trd=3/init_data=32'h10 the next cycle with wr_en=0; src1's write follows one cycle later.
- Drop: src2 pushes reg=1 then reg=7 -> the first is popped with no wr_en; only the reg=7 write appears.
- Backpressure: src0 pushes 2 entries with no arbitration gap possible (init_req held) -> src_ready[0]=0; after init_req drops, it returns to 1 one cycle after the first pop.
- Reset mid-flight: rst pulsed with 4 entries queued -> all outputs 0 immediately, no further wr_en after release, src_ready all 1s.

Source files
------------

// File: rtl/tk_pkg.sv
// Shared types and constants for the register-file writeback path.
package tk_pkg;

  localparam int unsigned NUM_TRD    = 8;
  localparam int unsigned TRD_W      = $clog2(NUM_TRD);
  localparam int unsigned REG_W      = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MIN_WR_REG = 2;

  typedef struct packed {
    logic [TRD_W-1:0]  trd;
    logic [REG_W-1:0]  reg_num;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // r0/r1 are hard-wired; writes to them are silently discarded.
  function automatic logic is_writable(input logic [REG_W-1:0] r);
    return r >= REG_W'(MIN_WR_REG);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of writeback requests; caller never pushes when full
// nor pops when empty.
module rf_wb_fifo
  import tk_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  wb_req_t       mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter in front of the per-thread register file,
// with thread-init priority. Optional TK_WB_CONFLICT_CNT_EN adds conflict_cnt.
module rf_wb_arbiter
  import tk_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TRD_W-1:0]  src_trd,
  input  logic [NUM_SRC*REG_W-1:0]  src_reg,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      init_req,
  input  logic [TRD_W-1:0]          init_req_trd,
  input  logic [DATA_W-1:0]         init_req_data,
  output logic                      init_ack,
  output logic                      wr_en,
  output logic [TRD_W-1:0]          wr_trd,
  output logic [REG_W-1:0]          reg_wr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      init,
  output logic [TRD_W-1:0]          init_trd,
  output logic [DATA_W-1:0]         init_data
`ifdef TK_WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]               conflict_cnt
`endif
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  wb_req_t            push_req [NUM_SRC];
  wb_req_t            head     [NUM_SRC];
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W:0]     cand_sum;
  logic               grant_vld;
  wb_req_t            grant_req;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign push_req[i] = '{trd:     src_trd[i*TRD_W +: TRD_W],
                           reg_num: src_reg[i*REG_W +: REG_W],
                           data:    src_data[i*DATA_W +: DATA_W]};
    assign push[i]     = src_valid[i] & ~full[i];

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (push_req[i]),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (head[i])
    );
  end

  assign src_ready = ~full;
  assign init_ack  = init_req & ~rst;

  // First non-empty FIFO at or after rr_ptr; init requests suppress any grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    pop       = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_SRC)) cand_sum = cand_sum - (PTR_W+1)'(NUM_SRC);
      cand = cand_sum[PTR_W-1:0];
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (init_req) grant_vld = 1'b0;
    if (grant_vld) pop[grant_idx] = 1'b1;
    grant_req = head[grant_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Registered regfile write and init buses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_trd    <= '0;
      reg_wr    <= '0;
      wr_data   <= '0;
      init      <= 1'b0;
      init_trd  <= '0;
      init_data <= '0;
    end else begin
      wr_en <= grant_vld && is_writable(grant_req.reg_num);
      init  <= init_req;
      if (grant_vld) begin
        wr_trd  <= grant_req.trd;
        reg_wr  <= grant_req.reg_num;
        wr_data <= grant_req.data;
      end
      if (init_req) begin
        init_trd  <= init_req_trd;
        init_data <= init_req_data;
      end
    end
  end

`ifdef TK_WB_CONFLICT_CNT_EN
  logic waiting;
  assign waiting = |(~empty & ~pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (waiting && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [8:0]  src_trd;
  logic [14:0] src_reg;
  logic [95:0] src_data;
  logic        init_req;
  logic [2:0]  init_req_trd;
  logic [31:0] init_req_data;
  logic        init_ack;
  logic        wr_en;
  logic [2:0]  wr_trd;
  logic [4:0]  reg_wr;
  logic [31:0] wr_data;
  logic        init;
  logic [2:0]  init_trd;
  logic [31:0] init_data;
`ifdef TK_WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  rf_wb_arbiter #(.NUM_SRC(3), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_trd       (src_trd),
    .src_reg       (src_reg),
    .src_data      (src_data),
    .init_req      (init_req),
    .init_req_trd  (init_req_trd),
    .init_req_data (init_req_data),
    .init_ack      (init_ack),
    .wr_en         (wr_en),
    .wr_trd        (wr_trd),
    .reg_wr        (reg_wr),
    .wr_data       (wr_data),
    .init          (init),
    .init_trd      (init_trd),
    .init_data     (init_data)
`ifdef TK_WB_CONFLICT_CNT_EN
    ,
    .conflict_cnt  (conflict_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [2:0] t,
                         input logic [4:0] r, input logic [31:0] d);
    src_valid[i]        = v;
    src_trd[i*3 +: 3]   = t;
    src_reg[i*5 +: 5]   = r;
    src_data[i*32 +: 32] = d;
  endtask

  initial begin
    rst           = 1'b1;
    src_valid     = '0;
    src_trd       = '0;
    src_reg       = '0;
    src_data      = '0;
    init_req      = 1'b1;
    init_req_trd  = 3'd0;
    init_req_data = 32'h0;
    step();
    step();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_init", 32'(init), 32'd0);
    chk("rst_init_ack", 32'(init_ack), 32'd0);
    init_req = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rst_src_ready", 32'(src_ready), 32'd7);

    // Round-robin: two entries per source, grants 0,1,2,0,1,2.
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 3'(i), 5'(8 + i), 32'hA000 + 32'(i * 16));
    step();
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 3'(i), 5'(8 + i), 32'hA000 + 32'(i * 16 + 1));
    chk("rr_lat_wr_en", 32'(wr_en), 32'd0);
    step();
    src_valid = '0;
    for (int k = 0; k < 6; k++) begin
      chk("rr_wr_en", 32'(wr_en), 32'd1);
      chk("rr_trd", 32'(wr_trd), 32'(k % 3));
      chk("rr_reg", 32'(reg_wr), 32'(8 + k % 3));
      chk("rr_data", wr_data, 32'hA000 + 32'((k % 3) * 16 + k / 3));
      step();
    end
    chk("rr_idle", 32'(wr_en), 32'd0);

    // Single source latency.
    set_src(0, 1'b1, 3'd2, 5'd5, 32'hDEAD_BEEF);
    step();
    src_valid = '0;
    chk("single_c1_wr_en", 32'(wr_en), 32'd0);
    step();
    chk("single_wr_en", 32'(wr_en), 32'd1);
    chk("single_trd", 32'(wr_trd), 32'd2);
    chk("single_reg", 32'(reg_wr), 32'd5);
    chk("single_data", wr_data, 32'hDEAD_BEEF);
    step();
    chk("single_pulse", 32'(wr_en), 32'd0);

    // Init priority over a non-empty src1.
    set_src(1, 1'b1, 3'd4, 5'd9, 32'h55);
    step();
    src_valid     = '0;
    init_req      = 1'b1;
    init_req_trd  = 3'd3;
    init_req_data = 32'h10;
    #1;
    chk("init_ack", 32'(init_ack), 32'd1);
    step();
    init_req = 1'b0;
    chk("init_strobe", 32'(init), 32'd1);
    chk("init_trd", 32'(init_trd), 32'd3);
    chk("init_data", init_data, 32'h10);
    chk("init_no_wr", 32'(wr_en), 32'd0);
    step();
    chk("init_after", 32'(init), 32'd0);
    chk("init_src1_wr_en", 32'(wr_en), 32'd1);
    chk("init_src1_reg", 32'(reg_wr), 32'd9);
    chk("init_src1_data", wr_data, 32'h55);
    step();
    chk("init_src1_pulse", 32'(wr_en), 32'd0);

    // Drop writes to r0/r1.
    set_src(2, 1'b1, 3'd6, 5'd1, 32'h11);
    step();
    set_src(2, 1'b1, 3'd6, 5'd7, 32'h77);
    step();
    src_valid = '0;
    chk("drop_no_wr", 32'(wr_en), 32'd0);
    step();
    chk("drop_wr_en", 32'(wr_en), 32'd1);
    chk("drop_reg", 32'(reg_wr), 32'd7);
    chk("drop_data", wr_data, 32'h77);
    step();
    chk("drop_pulse", 32'(wr_en), 32'd0);

    // Backpressure while init_req starves the sources.
    init_req      = 1'b1;
    init_req_trd  = 3'd1;
    init_req_data = 32'h20;
    set_src(0, 1'b1, 3'd5, 5'd3, 32'hB0);
    step();
    set_src(0, 1'b1, 3'd5, 5'd4, 32'hB1);
    step();
    src_valid = '0;
    chk("bp_full", 32'(src_ready), 32'd6);
    chk("bp_init", 32'(init), 32'd1);
    chk("bp_init_no_wr", 32'(wr_en), 32'd0);
    init_req = 1'b0;
    #1;
    chk("bp_still_full", 32'(src_ready), 32'd6);
    step();
    chk("bp_ready_back", 32'(src_ready), 32'd7);
    chk("bp_init_off", 32'(init), 32'd0);
    chk("bp_wr_a", wr_data, 32'hB0);
    chk("bp_wr_en_a", 32'(wr_en), 32'd1);
    step();
    chk("bp_wr_en_b", 32'(wr_en), 32'd1);
    chk("bp_wr_b", wr_data, 32'hB1);
    step();
    chk("bp_idle", 32'(wr_en), 32'd0);

    // Reset with four entries queued and an init pending.
    init_req = 1'b1;
    set_src(0, 1'b1, 3'd0, 5'd10, 32'hC0);
    set_src(1, 1'b1, 3'd1, 5'd11, 32'hC1);
    step();
    step();
    src_valid = '0;
    chk("mid_pre_init", 32'(init), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_wr_en", 32'(wr_en), 32'd0);
    chk("mid_init", 32'(init), 32'd0);
    chk("mid_init_ack", 32'(init_ack), 32'd0);
    step();
    rst      = 1'b0;
    init_req = 1'b0;
    #1;
    chk("mid_ready", 32'(src_ready), 32'd7);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_wr", 32'(wr_en), 32'd0);
      chk("mid_no_init", 32'(init), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
